// File: rtl/alu_driver.sv
// Sequencer that feeds an external combinational ALU from a 4-entry register
// file. It runs one command at a time: load-immediate or ALU op, then a response.
module alu_driver #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_dst,
  input  logic [1:0]   cmd_srca,
  input  logic [1:0]   cmd_srcb,
  input  logic [W-1:0] cmd_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_z,
  input  logic         alu_n,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags
);

  // Handshakes: a command transfers on a clk edge where cmd_valid & cmd_ready;
  // a response transfers on an edge where rsp_valid & rsp_ready. Once
  // rsp_valid rises it stays high with stable rsp_data/rsp_flags until the
  // transfer edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           ready_en_q;
  logic [W-1:0]   rf_q [4];
  logic [3:0]     flags_q;
  logic [W-1:0]   rsp_data_q;
  logic [W-1:0]   alu_a_q, alu_b_q;
  logic [2:0]     alu_ctrl_q;
  logic [1:0]     dst_q;
  logic           accept;
  logic           rsp_done;

  // ready_en_q keeps cmd_ready low during reset and until the first clk edge after release.
  assign cmd_ready = ready_en_q && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_done  = rsp_valid && rsp_ready;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = cmd_load ? RESP : EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sources are read at acceptance, so dst == src sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      flags_q    <= '0;
      rsp_data_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      dst_q      <= '0;
    end else begin
      if (accept) begin
        dst_q <= cmd_dst;
        if (cmd_load) begin
          rf_q[cmd_dst] <= cmd_imm;
          rsp_data_q    <= cmd_imm;
        end else begin
          alu_a_q    <= rf_q[cmd_srca];
          alu_b_q    <= rf_q[cmd_srcb];
          alu_ctrl_q <= cmd_op;
        end
      end
      if (state_q == EXEC) begin
        rf_q[dst_q] <= alu_out;
        rsp_data_q  <= alu_out;
        flags_q     <= {alu_n, alu_z, alu_co, alu_ovf};
      end
    end
  end

  a_rsp_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_flags))
  );

  a_ready_only_idle: assert property (
    @(posedge clk) disable iff (!rst_n)
      cmd_ready |-> (state_q == IDLE)
  );

endmodule
